// File: rtl/ddr3_memtest_seq_if.sv
// Avalon-MM bus between the memory-test sequencer (master) and the DDR3 EMIF
// local/user port as seen through the interconnect (slave).
//   avl_address       master -> slave  word address
//   avl_write         master -> slave  write request
//   avl_read          master -> slave  read request
//   avl_writedata     master -> slave  write data
//   avl_byteenable    master -> slave  byte enables
//   avl_waitrequest   slave  -> master command stall
//   avl_readdata      slave  -> master read data
//   avl_readdatavalid slave  -> master read data valid, in command order
interface ddr3_memtest_seq_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 64
) ();
    logic [ADDR_W-1:0]   avl_address;
    logic                avl_write;
    logic                avl_read;
    logic [DATA_W-1:0]   avl_writedata;
    logic [DATA_W/8-1:0] avl_byteenable;
    logic                avl_waitrequest;
    logic [DATA_W-1:0]   avl_readdata;
    logic                avl_readdatavalid;

    modport master (
        output avl_address, avl_write, avl_read, avl_writedata, avl_byteenable,
        input  avl_waitrequest, avl_readdata, avl_readdatavalid
    );

    modport slave (
        input  avl_address, avl_write, avl_read, avl_writedata, avl_byteenable,
        output avl_waitrequest, avl_readdata, avl_readdatavalid
    );
endinterface

// File: rtl/ddr3_memtest_seq.sv
// DDR3 memory-test sequencer. Once the EMIF reports init + calibration done,
// it writes the pattern P(a) = {DATA_W/32 {seed ^ a}} over the inclusive word
// range [start_addr, end_addr], then reads the range back with up to
// MAX_OUTSTANDING reads in flight and compares every returned beat.
//
// Ports:
//   clk_clk, reset_reset_n   EMIF user clock, synchronous active-low reset
//   start                    one-cycle launch pulse, honoured only when idle
//   start_addr, end_addr     inclusive word range, latched on accepted start
//   seed                     pattern seed, latched on accepted start
//   local_init_done, local_cal_success, local_cal_fail   EMIF status
//   busy                     accepted start .. test end
//   done                     one-cycle pulse at test end
//   pass                     result of the last test, held until next start
//   err_count                saturating mismatch count
//   first_err_addr           address of the first mismatch, 0 if none
//   avl                      Avalon-MM master port (ddr3_memtest_seq_if)
module ddr3_memtest_seq #(
    parameter int ADDR_W          = 25,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [31:0]       seed,
    input  logic              local_init_done,
    input  logic              local_cal_success,
    input  logic              local_cal_fail,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    ddr3_memtest_seq_if.master avl
);

    // One extra bit so the counter can hold MAX_OUTSTANDING itself.
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CAL,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] start_r, end_r;
    logic [31:0]       seed_r;
    logic [ADDR_W-1:0] addr;        // command address (write, then read pass)
    logic [ADDR_W-1:0] exp_addr;    // address of the next returning read beat
    logic [OW-1:0]     outstanding;

    logic wr_acc, rd_acc, rsp_ok, mismatch;

    function automatic logic [DATA_W-1:0] pat(input logic [31:0] s,
                                              input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = s ^ 32'(a);
        return {(DATA_W/32){w}};
    endfunction

    // ------------------------------------------------------------------
    // Bus outputs: Moore-style, derived from registered state only, so the
    // command stays stable for as long as waitrequest holds it off.
    // ------------------------------------------------------------------
    assign avl.avl_write      = (state == S_WRITE);
    assign avl.avl_read       = (state == S_READ) && (outstanding < MAX_OUT);
    assign avl.avl_address    = addr;
    assign avl.avl_writedata  = (state == S_WRITE) ? pat(seed_r, addr) : '0;
    assign avl.avl_byteenable = '1;

    assign wr_acc = avl.avl_write && !avl.avl_waitrequest;
    assign rd_acc = avl.avl_read  && !avl.avl_waitrequest;

    // Only beats belonging to reads issued by this test are compared. Beats
    // seen with nothing outstanding (e.g. late responses to reads cut off by
    // a reset) are dropped so they cannot corrupt the count.
    assign rsp_ok   = avl.avl_readdatavalid
                   && ((state == S_READ) || (state == S_DRAIN))
                   && (outstanding != '0);
    assign mismatch = rsp_ok && (avl.avl_readdata != pat(seed_r, exp_addr));

    assign busy = (state != S_IDLE) && (state != S_FINISH);
    assign done = (state == S_FINISH);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = S_WAIT_CAL;
            end
            S_WAIT_CAL: begin
                // Calibration failure wins; the range check is only
                // consulted once calibration has succeeded.
                if (local_cal_fail)
                    state_nxt = S_FINISH;
                else if (local_init_done && local_cal_success)
                    state_nxt = (start_r > end_r) ? S_FINISH : S_WRITE;
            end
            S_WRITE: begin
                if (wr_acc && (addr == end_r))
                    state_nxt = S_READ;
            end
            S_READ: begin
                if (rd_acc && (addr == end_r))
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (outstanding == '0)
                    state_nxt = S_FINISH;
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Datapath: latched test parameters and command address
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            start_r <= '0;
            end_r   <= '0;
            seed_r  <= '0;
            addr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        start_r <= start_addr;
                        end_r   <= end_addr;
                        seed_r  <= seed;
                        addr    <= start_addr;
                    end
                end
                S_WRITE: begin
                    // Equality terminal check: a range ending at the top
                    // address never needs addr to wrap.
                    if (wr_acc)
                        addr <= (addr == end_r) ? start_r : addr + 1'b1;
                end
                S_READ: begin
                    if (rd_acc && (addr != end_r))
                        addr <= addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-read tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            outstanding <= '0;
        end else begin
            case ({rd_acc, rsp_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Compare path and result
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            exp_addr       <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else begin
            if ((state == S_IDLE) && start) begin
                exp_addr       <= start_addr;
                err_count      <= '0;
                first_err_addr <= '0;
                pass           <= 1'b0;
            end else begin
                if (rsp_ok)
                    exp_addr <= exp_addr + 1'b1;
                if (mismatch) begin
                    if (err_count != 16'hFFFF)
                        err_count <= err_count + 1'b1;
                    if (err_count == '0)
                        first_err_addr <= exp_addr;
                end
                // Result is settled on entry to FINISH so it is valid in
                // the same cycle as done. Entry from WAIT_CAL means a
                // calibration or range failure. Entry from DRAIN needs
                // outstanding == 0, so no beat can still be updating
                // err_count in that cycle.
                if ((state != S_FINISH) && (state_nxt == S_FINISH))
                    pass <= (state == S_DRAIN) && (err_count == '0);
            end
        end
    end

endmodule

// File: tb/tb_ddr3_memtest_seq.sv
module tb_ddr3_memtest_seq;
    localparam int AW = 25;
    localparam int DW = 64;
    localparam int MO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, init_done, cal_ok, cal_fail;
    logic [AW-1:0] s_addr, e_addr;
    logic [31:0]   seed;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err;

    ddr3_memtest_seq_if #(.ADDR_W(AW), .DATA_W(DW)) avl_if ();

    ddr3_memtest_seq #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .start             (start),
        .start_addr        (s_addr),
        .end_addr          (e_addr),
        .seed              (seed),
        .local_init_done   (init_done),
        .local_cal_success (cal_ok),
        .local_cal_fail    (cal_fail),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .err_count         (err_count),
        .first_err_addr    (first_err),
        .avl               (avl_if)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] pat(input logic [31:0] s, input int a);
        logic [31:0] w;
        w = s ^ a;
        return {w, w};
    endfunction

    // ---------------- memory / slave model ----------------
    typedef struct { int due; logic [63:0] data; } rsp_t;
    logic [63:0] mem [int];
    bit          corrupt [int];
    rsp_t        rq [$];
    int cyc = 0, outst = 0, peak = 0, last_due = 0;
    int lat_min = 2, lat_max = 2, wr_pct = 0;
    int exp_w, exp_r, n_wr, n_rd, traffic, bus_err, stab_err, first_wr_cyc, last_wr_cyc;
    logic          p_stall = 1'b0, p_wr = 1'b0, p_rd = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [63:0]   p_data = '0;
    logic          m_w;
    rsp_t          m_r;
    int            m_a, m_d;
    logic [63:0]   m_dd;

    // DUT bus outputs depend only on its registered state, so commands seen
    // here at the negedge together with the waitrequest chosen here are
    // exactly what the slave accepts at the following posedge.
    always @(negedge clk) begin
        cyc++;
        m_w = (wr_pct > 0) && (int'($urandom_range(99)) < wr_pct);
        avl_if.avl_waitrequest = m_w;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            m_r = rq.pop_front();
            avl_if.avl_readdatavalid = 1'b1;
            avl_if.avl_readdata      = m_r.data;
            outst--;
        end else begin
            avl_if.avl_readdatavalid = 1'b0;
            avl_if.avl_readdata      = {$urandom, $urandom};
        end
        if (p_stall && (avl_if.avl_write !== p_wr || avl_if.avl_read !== p_rd ||
                        avl_if.avl_address !== p_addr ||
                        (p_wr && avl_if.avl_writedata !== p_data)))
            stab_err++;
        if (avl_if.avl_write && !m_w) begin
            m_a = int'(avl_if.avl_address);
            mem[m_a] = avl_if.avl_writedata;
            if (m_a != exp_w || avl_if.avl_writedata !== pat(seed, m_a)) bus_err++;
            exp_w++;
            if (n_wr == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            n_wr++;
        end
        if (avl_if.avl_read && !m_w) begin
            m_a  = int'(avl_if.avl_address);
            m_dd = mem.exists(m_a) ? mem[m_a] : 64'h0;
            if (corrupt.exists(m_a)) m_dd = m_dd ^ (64'h1 << (m_a % 64));
            m_d = cyc + int'($urandom_range(lat_max, lat_min));
            if (m_d <= last_due) m_d = last_due + 1;
            last_due = m_d;
            rq.push_back('{m_d, m_dd});
            outst++;
            if (outst > peak) peak = outst;
            if (m_a != exp_r) bus_err++;
            exp_r++;
            n_rd++;
        end
        if (avl_if.avl_write || avl_if.avl_read) traffic++;
        p_stall = (avl_if.avl_write || avl_if.avl_read) && m_w;
        p_wr    = avl_if.avl_write;
        p_rd    = avl_if.avl_read;
        p_addr  = avl_if.avl_address;
        p_data  = avl_if.avl_writedata;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".ctl"}, {busy, done, pass, avl_if.avl_write, avl_if.avl_read}, 64'h0);
        chk({tag, ".err"}, err_count, 64'h0);
        chk({tag, ".ferr"}, first_err, 64'h0);
        chk({tag, ".addr"}, avl_if.avl_address, 64'h0);
        chk({tag, ".wdata"}, avl_if.avl_writedata, 64'h0);
        chk({tag, ".be"}, avl_if.avl_byteenable, 64'hFF);
    endtask

    // Runs one test and compares against results derived directly from the
    // range, the corrupted-address set and the calibration status.
    task automatic run(input string tag, input int s, input int e,
                       input logic [31:0] sd, input bit hold_cal);
        int ne, fe, to, nexp;
        bit ok;
        exp_w = s; exp_r = s; n_wr = 0; n_rd = 0; traffic = 0;
        bus_err = 0; stab_err = 0; peak = outst;
        ne = 0; fe = 0;
        for (int a = s; a <= e; a++)
            if (corrupt.exists(a)) begin
                if (ne == 0) fe = a;
                ne++;
            end
        nexp = (s <= e) ? e - s + 1 : 0;
        ok   = (s <= e) && (ne == 0);
        s_addr = s[AW-1:0];
        e_addr = e[AW-1:0];
        seed   = sd;
        if (hold_cal) init_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy"}, busy, 1);
        if (hold_cal) begin
            for (int i = 0; i < 500 && rq.size() > 0; i++) tick();
            chk({tag, ".stale_drained"}, rq.size(), 0);
            repeat (2) tick();
            init_done = 1'b1;
        end
        to = 0;
        while (!done && to < 20000) begin
            tick();
            to++;
        end
        chk({tag, ".done"}, done, 1);
        chk({tag, ".pass"}, pass, ok);
        chk({tag, ".err_count"}, err_count, (ne > 65535) ? 65535 : ne);
        chk({tag, ".first_err"}, first_err, fe);
        chk({tag, ".n_wr"}, n_wr, nexp);
        chk({tag, ".n_rd"}, n_rd, nexp);
        chk({tag, ".bus_seq"}, bus_err, 0);
        chk({tag, ".stable"}, stab_err, 0);
        chk({tag, ".outst_le_max"}, peak <= MO, 1);
        tick();
        chk({tag, ".done_pulse"}, {done, busy}, 0);
        chk({tag, ".pass_held"}, pass, ok);
    endtask

    initial begin
        int s, e, to;
        rst_n = 1'b0; start = 1'b0; init_done = 1'b1; cal_ok = 1'b1; cal_fail = 1'b0;
        s_addr = '0; e_addr = '0; seed = '0;
        repeat (3) tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // Ideal memory, no stalls.
        wr_pct = 0; lat_min = 2; lat_max = 2;
        run("t1", 'h10, 'h1F, 32'hA5A5_0000, 0);
        chk("t1.wr_consec", last_wr_cyc - first_wr_cyc, 15);

        // Two corrupted words.
        corrupt[32'h14] = 1'b1;
        corrupt[32'h1A] = 1'b1;
        run("t2", 'h10, 'h1F, 32'hA5A5_0000, 0);
        corrupt.delete();

        // Random stalls and response latency.
        wr_pct = 50; lat_min = 3; lat_max = 20;
        run("t3", 0, 255, $urandom, 0);

        // Calibration failure while waiting.
        wr_pct = 0; lat_min = 2; lat_max = 2;
        init_done = 1'b0; cal_ok = 1'b0; traffic = 0;
        s_addr = 'h10; e_addr = 'h1F;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("calf.busy", busy, 1);
        cal_fail = 1'b1;
        for (int i = 0; i < 2 && !done; i++) tick();
        chk("calf.done", done, 1);
        chk("calf.pass", pass, 0);
        chk("calf.traffic", traffic, 0);
        cal_fail = 1'b0; init_done = 1'b1; cal_ok = 1'b1;
        tick();

        // Reversed range, then single word.
        run("rev", 'h20, 'h1F, 32'h1234_5678, 0);
        chk("rev.traffic", traffic, 0);
        run("one", 5, 5, 32'hDEAD_BEEF, 0);

        // Top of the address space: no wrap on the equality check.
        wr_pct = 30; lat_min = 1; lat_max = 6;
        run("top", (1 << AW) - 4, (1 << AW) - 1, $urandom, 0);

        // Randomized ranges, seeds, corruptions, stalls and latency.
        for (int k = 0; k < 3; k++) begin
            s = int'($urandom_range(200));
            e = s + int'($urandom_range(60));
            corrupt.delete();
            repeat ($urandom_range(3)) corrupt[s + int'($urandom_range(e - s))] = 1'b1;
            wr_pct  = int'($urandom_range(60));
            lat_min = 1 + int'($urandom_range(4));
            lat_max = lat_min + int'($urandom_range(12));
            run($sformatf("rnd%0d", k), s, e, $urandom, 0);
        end
        corrupt.delete();

        // Reset in the middle of the read pass.
        wr_pct = 0; lat_min = 12; lat_max = 12;
        s_addr = 'h10; e_addr = 'h4F; seed = $urandom;
        exp_w = 'h10; exp_r = 'h10; n_wr = 0; n_rd = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        to = 0;
        while (outst != 5 && to < 1000) begin
            tick();
            to++;
        end
        chk("rst.outst5", outst, 5);
        chk("rst.reading", avl_if.avl_read, 1);
        rst_n = 1'b0;
        tick();
        chk_reset("rst_mid");
        rst_n = 1'b1;
        tick();
        run("rst_fresh", 'h10, 'h1F, $urandom, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ddr3_memtest_seq.md
Name: ddr3_memtest_seq

Overview:
- Hardware DDR3 memory-test sequencer; an Avalon-MM master on the DDR3 EMIF local (user) port.
- Shares that port with the Nios II data master through the interconnect.
- After the EMIF reports init and calibration complete, it writes an address-derived pattern over an inclusive word range, then reads the range back and compares, with pipelined reads.
- Reports pass/fail, a saturating error count and the first failing address, for software readout and board bring-up.

Parameters:
- ADDR_W, 25, local-interface word address width.
- DATA_W, 64, local-interface data width; must be a multiple of 32.
- MAX_OUTSTANDING, 8, maximum in-flight read commands; power of two, 2..32.

Ports:
- clk_clk  in  1  EMIF user clock (afi_half_clk domain); all logic on rising edge.
- reset_reset_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; launches a test when idle.
- start_addr  in  ADDR_W  first word address; sampled on accepted start.
- end_addr  in  ADDR_W  last word address, inclusive; sampled on accepted start.
- seed  in  32  pattern seed; sampled on accepted start.
- local_init_done  in  1  EMIF status.
- local_cal_success  in  1  EMIF status.
- local_cal_fail  in  1  EMIF status.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  result of last test; held until next accepted start.
- err_count  out  16  mismatch count, saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of first mismatch; 0 if none.
- avl_address  out  ADDR_W  Avalon word address.
- avl_write  out  1  write request.
- avl_read  out  1  read request.
- avl_writedata  out  DATA_W  write data.
- avl_byteenable  out  DATA_W/8  byte enables; always all ones.
- avl_waitrequest  in  1  stall; a command is accepted when req && !avl_waitrequest.
- avl_readdata  in  DATA_W  read data.
- avl_readdatavalid  in  1  read data valid; responses arrive in order.

Behaviour:
- Reset values:
  - busy, done, pass, avl_write and avl_read = 0.
  - err_count, first_err_addr, avl_address and avl_writedata = 0.
  - byteenable = all ones.
  - Internal state = IDLE; outstanding counter = 0.
- Pattern: P(a) = the 32-bit word (seed XOR zero-extended a), replicated DATA_W/32 times.
- State IDLE:
  - On start: latch inputs, clear err_count and first_err_addr, set busy, go to WAIT_CAL.
  - start while busy is ignored.
- State WAIT_CAL:
  - If local_cal_fail: go to FINISH with pass = 0 and no bus traffic.
  - Else if local_init_done && local_cal_success: go to WRITE.
  - Else stay.
- Range check: if start_addr > end_addr, go straight to FINISH with pass = 0 and no bus traffic. This check takes precedence after the calibration check.
- State WRITE:
  - avl_write = 1, avl_address = addr, avl_writedata = P(addr).
  - Signals are held stable while avl_waitrequest is high.
  - On accept: if addr == end_addr, reload addr = start_addr and go to READ; else addr + 1.
  - No idle cycle between accepted writes, i.e. one write per cycle when waitrequest is low.
- State READ:
  - avl_read = 1 whenever outstanding < MAX_OUTSTANDING; address is held stable while stalled.
  - On accept of the end_addr read, go to DRAIN.
- Outstanding counter:
  - +1 on accepted read; -1 on avl_readdatavalid.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING.
- Compare path:
  - A separate expected-address counter starts at start_addr and increments on each avl_readdatavalid.
  - Mismatch (avl_readdata != P(exp_addr)): err_count += 1, saturating.
  - first_err_addr is captured only on the first mismatch of the test.
- State DRAIN: wait for outstanding == 0, then go to FINISH.
- State FINISH (one cycle):
  - done = 1, busy = 0.
  - pass = (err_count == 0 and no calibration or range failure). pass includes a mismatch on the final beat.
  - Go to IDLE.
- avl_readdatavalid in IDLE, WAIT_CAL or WRITE is ignored.
- Reset mid-operation: all outputs return to reset values on the next edge and avl_read/avl_write drop. Late responses from in-flight reads are ignored.
- Single-word range (start_addr == end_addr): 1 write, 1 read, valid result.
- Full range start = 0, end = all ones: the terminal check is equality, so no address wrap occurs.

Test Plan:
- Range 0x10..0x1F, seed 0xA5A5_0000, ideal memory model, waitrequest 0 -> 16 writes on consecutive cycles, 16 reads; done with pass = 1, err_count = 0, first_err_addr = 0.
- Same range; model corrupts the word at 0x14 and 0x1A -> pass = 0, err_count = 2, first_err_addr = 0x14.
- Random waitrequest (50%) and readdatavalid latency 3..20 cycles, range 0..255 -> outstanding never exceeds 8, avl_address/writedata stable while stalled, pass = 1.
- local_cal_fail asserted while in WAIT_CAL -> done within 2 cycles, pass = 0, no avl_read/avl_write ever asserted.
- start_addr 0x20 > end_addr 0x1F -> pass = 0, no bus traffic; then start_addr == end_addr == 0x5 -> exactly 1 write and 1 read, pass = 1.
- reset_reset_n low for 1 cycle during READ with 5 reads outstanding -> all outputs at reset values next cycle; a fresh start completes with pass = 1 despite stale readdatavalid pulses.
